// File: rtl/tank_pkg.sv
// Shared types and widths for the bullet arbiter and its per-slot storage.
package tank_pkg;

  typedef enum logic {
    TANK1 = 1'b0,
    TANK2 = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COOL  = 2'd2
  } arb_state_t;

  localparam int SLOT_IDX_W = 3;
  localparam int LIFE_W     = 10;
  localparam int COOL_W     = 8;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: live flag, owning tank and lifetime countdown.
// A load always wins; kill and expiry in the same frame free the slot exactly once.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = 300
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_load,
  input  owner_t i_owner,
  input  logic   i_kill,
  input  logic   i_flush,
  output logic   o_active,
  output owner_t o_owner
);

  logic              r_active;
  owner_t            r_owner;
  logic [LIFE_W-1:0] r_life;

  always_ff @(posedge i_clk) begin
    // NOTE: the lifetime counter is reset along with the flag so no stale count survives a reset.
    if (!i_rst_n || i_flush) begin
      r_active <= 1'b0;
      r_owner  <= TANK1;
      r_life   <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_owner  <= i_owner;
      r_life   <= LIFE_W'(LIFETIME);
    end else if (r_active) begin
      if (i_kill || r_life <= LIFE_W'(1)) begin
        r_active <= 1'b0;
        r_owner  <= TANK1;
        r_life   <= '0;
      end else begin
        r_life <= r_life - LIFE_W'(1);
      end
    end
  end

  assign o_active = r_active;
  assign o_owner  = r_owner;

endmodule

// File: rtl/bullet_arbiter.sv
// Bullet pool arbiter: per-tank fire FSMs, round-robin grant, lowest-free-slot allocation.
// Build macro BULLET_AUTOFIRE_EN: a held shoot_req re-arms the tank when its cooldown ends.
module bullet_arbiter
  import tank_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_PER_TANK = 2,
  parameter int LIFETIME     = 300,
  parameter int COOLDOWN     = 15
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic [1:0]            shoot_req,
  input  logic [1:0]            game_end,
  input  logic [NUM_SLOTS-1:0]  slot_kill,
  output logic                  launch_valid,
  output logic [SLOT_IDX_W-1:0] launch_slot,
  output logic                  launch_owner,
  output logic [NUM_SLOTS-1:0]  slot_active,
  output logic [NUM_SLOTS-1:0]  slot_owner,
  output logic [1:0][1:0]       ammo_left
);

`ifdef BULLET_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  logic [1:0]            r_req_d;
  arb_state_t            r_state [2];
  logic [COOL_W-1:0]     r_cool  [2];
  owner_t                r_rr;
  logic                  r_launch_valid;
  logic [SLOT_IDX_W-1:0] r_launch_slot;
  owner_t                r_launch_owner;

  logic                  w_flush;
  logic [1:0]            w_rise;
  logic [NUM_SLOTS-1:0]  w_slot_act;
  owner_t                w_slot_own [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  w_load;
  logic                  w_free_found;
  logic [SLOT_IDX_W-1:0] w_free_idx;
  logic [1:0][3:0]       w_live;
  logic [1:0]            w_elig;
  logic                  w_grant;
  owner_t                w_grant_owner;
  logic [1:0]            w_grant_vec;

  assign w_flush = |game_end;
  assign w_rise  = shoot_req & ~r_req_d;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign w_load[g] = w_grant && (w_free_idx == SLOT_IDX_W'(g));

    bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
      .i_clk    (frame_clk),
      .i_rst_n  (Reset_n),
      .i_load   (w_load[g]),
      .i_owner  (w_grant_owner),
      .i_kill   (slot_kill[g]),
      .i_flush  (w_flush),
      .o_active (w_slot_act[g]),
      .o_owner  (w_slot_own[g])
    );

    assign slot_owner[g] = w_slot_own[g];
  end

  // Allocation and ammo both look only at registered slot state, so a slot freed
  // this frame is not reusable until the next one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_live       = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!w_slot_act[s]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_IDX_W'(s);
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (w_slot_act[s]) begin
        if (w_slot_own[s] == TANK2) w_live[1] = w_live[1] + 4'd1;
        else                        w_live[0] = w_live[0] + 4'd1;
      end
    end
    for (int t = 0; t < 2; t++) begin
      ammo_left[t] = (w_live[t] >= 4'(MAX_PER_TANK)) ? 2'd0
                                                     : 2'(4'(MAX_PER_TANK) - w_live[t]);
      w_elig[t]    = (r_state[t] == ARMED) && shoot_req[t] &&
                     (ammo_left[t] != 2'd0) && w_free_found;
    end
  end

  assign w_grant       = (|w_elig) && !w_flush;
  assign w_grant_owner = (&w_elig) ? r_rr : (w_elig[1] ? TANK2 : TANK1);
  assign w_grant_vec   = !w_grant              ? 2'b00 :
                         (w_grant_owner == TANK2) ? 2'b10 : 2'b01;

  always_ff @(posedge frame_clk) begin
    // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
    if (!Reset_n) begin
      r_req_d        <= 2'b00;
      r_rr           <= TANK1;
      r_launch_valid <= 1'b0;
      r_launch_slot  <= '0;
      r_launch_owner <= TANK1;
      for (int t = 0; t < 2; t++) begin
        r_state[t] <= IDLE;
        r_cool[t]  <= '0;
      end
    end else begin
      r_req_d        <= shoot_req;
      r_launch_valid <= w_grant;
      r_launch_slot  <= w_grant ? w_free_idx : '0;
      r_launch_owner <= w_grant ? w_grant_owner : TANK1;
      if (w_grant) r_rr <= (w_grant_owner == TANK1) ? TANK2 : TANK1;

      for (int t = 0; t < 2; t++) begin
        if (w_flush) begin
          r_state[t] <= IDLE;
          r_cool[t]  <= '0;
        end else begin
          case (r_state[t])
            IDLE: if (w_rise[t]) r_state[t] <= ARMED;
            ARMED: begin
              if (w_grant_vec[t]) begin
                r_state[t] <= COOL;
                r_cool[t]  <= COOL_W'(COOLDOWN);
              end else if (!shoot_req[t]) begin
                r_state[t] <= IDLE;
              end
            end
            COOL: begin
              // Leaving on the 1->0 step gives a re-fire spacing of COOLDOWN+1 frames.
              if (r_cool[t] <= COOL_W'(1)) begin
                r_cool[t]  <= '0;
                r_state[t] <= (AUTOFIRE && shoot_req[t]) ? ARMED : IDLE;
              end else begin
                r_cool[t] <= r_cool[t] - COOL_W'(1);
              end
            end
            default: r_state[t] <= IDLE;
          endcase
        end
      end
    end
  end

  assign launch_valid = r_launch_valid;
  assign launch_slot  = r_launch_slot;
  assign launch_owner = r_launch_owner;
  assign slot_active  = w_slot_act;

endmodule

// File: tb/tb_bullet_arbiter.sv
// Scoreboard bench for bullet_arbiter: a frame-level reference model predicts pool state and
// launches; a monitor compares them against the DUT one time unit after each rising edge.
module tb_bullet_arbiter;

  localparam int NUM_SLOTS    = 4;
  localparam int MAX_PER_TANK = 2;
  localparam int LIFETIME     = 300;
  localparam int COOLDOWN     = 15;
`ifdef BULLET_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  logic                 frame_clk = 1'b0;
  logic                 Reset_n   = 1'b0;
  logic [1:0]           shoot_req = 2'b00;
  logic [1:0]           game_end  = 2'b00;
  logic [NUM_SLOTS-1:0] slot_kill = '0;
  logic                 launch_valid;
  logic [2:0]           launch_slot;
  logic                 launch_owner;
  logic [NUM_SLOTS-1:0] slot_active;
  logic [NUM_SLOTS-1:0] slot_owner;
  logic [1:0][1:0]      ammo_left;

  always #5 frame_clk = ~frame_clk;

  bullet_arbiter #(
    .NUM_SLOTS(NUM_SLOTS), .MAX_PER_TANK(MAX_PER_TANK),
    .LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .shoot_req    (shoot_req),
    .game_end     (game_end),
    .slot_kill    (slot_kill),
    .launch_valid (launch_valid),
    .launch_slot  (launch_slot),
    .launch_owner (launch_owner),
    .slot_active  (slot_active),
    .slot_owner   (slot_owner),
    .ammo_left    (ammo_left)
  );

  typedef struct {
    int                   id;
    logic [NUM_SLOTS-1:0] act;
    logic [NUM_SLOTS-1:0] own;
    int                   ammo0;
    int                   ammo1;
    bit                   lv;
  } snap_t;

  typedef struct {
    int id;
    int slot;
    int owner;
  } launch_t;

  snap_t   snap_q[$];
  launch_t launch_q[$];
  int      n_vec   = 0;
  int      n_miss  = 0;
  int      step_id = 0;

  // Reference model: frames of life left per slot (0 = free), cooldown frames left per tank.
  int m_life [NUM_SLOTS];
  int m_own  [NUM_SLOTS];
  bit m_wait [2];
  int m_cool [2];
  bit m_prev [2];
  int m_turn;

  task automatic check(input string name, input int id, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("FAIL %s at frame %0d: got %0d, expected %0d", name, id, actual, expected);
    end
  endtask

  task automatic model_edge(input bit rst_n, input logic [1:0] req, input logic [1:0] ge,
                            input logic [NUM_SLOTS-1:0] kill);
    int    ammo [2];
    bit    elig [2];
    int    free_s;
    int    winner;
    snap_t s;
    winner = -1;
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin m_life[i] = 0; m_own[i] = 0; end
      for (int t = 0; t < 2; t++) begin m_wait[t] = 0; m_cool[t] = 0; m_prev[t] = 0; end
      m_turn = 0;
    end else begin
      ammo[0] = MAX_PER_TANK;
      ammo[1] = MAX_PER_TANK;
      for (int i = 0; i < NUM_SLOTS; i++) if (m_life[i] > 0) ammo[m_own[i]]--;
      free_s = -1;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) if (m_life[i] == 0) free_s = i;
      for (int t = 0; t < 2; t++) elig[t] = m_wait[t] && req[t] && ammo[t] > 0 && free_s >= 0;
      if (ge == 0) begin
        if (elig[0] && elig[1]) winner = m_turn;
        else if (elig[0])       winner = 0;
        else if (elig[1])       winner = 1;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (ge != 0)                              m_life[i] = 0;
        else if (m_life[i] > 0 && (kill[i] || m_life[i] == 1)) m_life[i] = 0;
        else if (m_life[i] > 0)                   m_life[i]--;
      end
      if (winner >= 0) begin
        m_life[free_s] = LIFETIME;
        m_own[free_s]  = winner;
        m_turn         = 1 - winner;
        launch_q.push_back('{id: step_id, slot: free_s, owner: winner});
      end
      for (int t = 0; t < 2; t++) begin
        if (ge != 0) begin
          m_wait[t] = 0;
          m_cool[t] = 0;
        end else if (m_cool[t] > 0) begin
          m_cool[t]--;
          if (m_cool[t] == 0 && AUTOFIRE && req[t]) m_wait[t] = 1;
        end else if (m_wait[t]) begin
          if (winner == t) begin
            m_wait[t] = 0;
            m_cool[t] = COOLDOWN;
          end else if (!req[t]) begin
            m_wait[t] = 0;
          end
        end else if (req[t] && !m_prev[t]) begin
          m_wait[t] = 1;
        end
        m_prev[t] = req[t];
      end
    end
    s.id    = step_id;
    s.act   = '0;
    s.own   = '0;
    s.ammo0 = MAX_PER_TANK;
    s.ammo1 = MAX_PER_TANK;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (m_life[i] > 0) begin
        s.act[i] = 1'b1;
        s.own[i] = (m_own[i] == 1);
        if (m_own[i] == 1) s.ammo1--; else s.ammo0--;
      end
    end
    s.lv = (winner >= 0);
    snap_q.push_back(s);
    step_id++;
  endtask

  task automatic step(input bit rst_n, input logic [1:0] req, input logic [1:0] ge,
                      input logic [NUM_SLOTS-1:0] kill);
    @(negedge frame_clk);
    Reset_n   = rst_n;
    shoot_req = req;
    game_end  = ge;
    slot_kill = kill;
    model_edge(rst_n, req, ge, kill);
  endtask

  task automatic hold(input int n, input bit rst_n, input logic [1:0] req);
    repeat (n) step(rst_n, req, 2'b00, '0);
  endtask

  // Monitor: one expected snapshot per edge; launches are matched against the launch queue.
  initial begin : monitor
    snap_t   s;
    launch_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (snap_q.size() != 0) begin
        s = snap_q.pop_front();
        check("slot_active",  s.id, int'(slot_active),  int'(s.act));
        check("slot_owner",   s.id, int'(slot_owner),   int'(s.own));
        check("ammo_tank1",   s.id, int'(ammo_left[0]), s.ammo0);
        check("ammo_tank2",   s.id, int'(ammo_left[1]), s.ammo1);
        check("launch_valid", s.id, int'(launch_valid), int'(s.lv));
        if (launch_valid) begin
          check("launch_expected", s.id, int'(launch_q.size() > 0), 1);
          if (launch_q.size() > 0) begin
            e = launch_q.pop_front();
            check("launch_frame", s.id, s.id, e.id);
            check("launch_slot",  s.id, int'(launch_slot),  e.slot);
            check("launch_owner", s.id, int'(launch_owner), e.owner);
          end
        end else if (s.lv && launch_q.size() > 0 && launch_q[0].id == s.id) begin
          void'(launch_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0]           r_req;
    logic [1:0]           ge;
    logic [NUM_SLOTS-1:0] kill;
    bit                   rn;

    hold(3, 1'b0, 2'b00);
    // Single tank1 request held for 40 frames.
    hold(4, 1'b1, 2'b00);
    hold(40, 1'b1, 2'b01);
    hold(3, 1'b1, 2'b00);

    // Simultaneous rise after reset, then a second round to fill the pool.
    hold(2, 1'b0, 2'b00);
    hold(3, 1'b1, 2'b11);
    hold(20, 1'b1, 2'b00);
    hold(3, 1'b1, 2'b11);
    hold(20, 1'b1, 2'b00);
    // Pool full: tank1 waits, slot 2 is killed, relaunch must wait for the freed state.
    hold(5, 1'b1, 2'b01);
    step(1'b1, 2'b01, 2'b00, 4'b0100);
    hold(5, 1'b1, 2'b01);
    hold(2, 1'b1, 2'b00);
    // Let every bullet age out on its own.
    hold(310, 1'b1, 2'b00);

    // Round end with three live slots and a pending request.
    hold(2, 1'b0, 2'b00);
    hold(3, 1'b1, 2'b11);
    hold(20, 1'b1, 2'b00);
    hold(3, 1'b1, 2'b01);
    hold(20, 1'b1, 2'b00);
    step(1'b1, 2'b10, 2'b00, '0);
    step(1'b1, 2'b10, 2'b01, '0);
    hold(3, 1'b1, 2'b10);
    hold(2, 1'b1, 2'b00);

    // Reset in the middle of a cooldown with a bullet in flight.
    hold(3, 1'b1, 2'b01);
    hold(5, 1'b1, 2'b00);
    hold(1, 1'b0, 2'b01);
    hold(4, 1'b1, 2'b01);
    hold(2, 1'b1, 2'b00);

    // Randomised play.
    r_req = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      rn   = 1'b1;
      ge   = 2'b00;
      kill = '0;
      for (int t = 0; t < 2; t++) if ($urandom_range(0, 7) == 0) r_req[t] = ~r_req[t];
      for (int s = 0; s < NUM_SLOTS; s++) if ($urandom_range(0, 29) == 0) kill[s] = 1'b1;
      if ($urandom_range(0, 399) == 0) ge = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 999) == 0) rn = 1'b0;
      step(rn, r_req, ge, kill);
    end
    hold(3, 1'b1, 2'b00);

    @(posedge frame_clk);
    #2;
    check("launches_outstanding", step_id, launch_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
